data_mem_responder: RTL and testbench

//  Single-port byte-wide data memory with a valid/ready request/response handshake.

---
 rtl/data_mem_responder.sv | 106 ++++++++++
 tb/tb_data_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Single-port data memory behind a valid/ready request/response handshake.
// It serves one load or store at a time after a fixed access latency and flags out-of-range addresses.
module data_mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic              access;

    assign in_range = ({1'b0, lat_addr} < (ADDR_W + 1)'(DEPTH));
    assign access   = (state == BUSY) && (cnt == '0);

    // Storage is deliberately left out of reset; a reset forces IDLE, which blocks any pending write.
    always_ff @(posedge clk) begin
        if (access && lat_we && in_range) begin
            mem[lat_addr] <= lat_wdata;
        end
    end

    // Request/response control; outputs are registered and only change on state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= CNT_W'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                        if (!in_range) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (lat_we) begin
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end else begin
                            resp_err   <= 1'b0;
                            resp_rdata <= mem[lat_addr];
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a plain array memory model.
// Instance 0 uses DEPTH=200/WAIT_CYCLES=2, and instance 1 uses DEPTH=256/WAIT_CYCLES=0.
module tb_data_mem_responder;

    logic            clk;
    logic [1:0]      rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [1:0][7:0] req_addr;
    logic [1:0][7:0] req_wdata;
    logic [1:0]      resp_valid;
    logic [1:0]      resp_ready;
    logic [1:0][7:0] resp_rdata;
    logic [1:0]      resp_err;

    int checkCount = 0;
    int failCount  = 0;
    int cycle      = 0;
    int acceptCycle [2];
    int depthModel  [2] = '{200, 256};
    int waitModel   [2] = '{2, 0};
    logic [7:0] memModel [2][256];

    data_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) dutA (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dutB (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, actual, expected, cycle);
        end
    endtask

    // Runs one full transaction from a negedge and returns at the negedge after the handshake edge.
    task automatic applyStimulus(input int idx, input logic we, input logic [7:0] addr,
                                 input logic [7:0] wdata, input int hold);
        int waited;
        int edges;
        logic expErr;
        logic [7:0] expData;
        expErr  = (int'(addr) >= depthModel[idx]);
        expData = (expErr || we) ? 8'h00 : memModel[idx][addr];
        req_we[idx]     = we;
        req_addr[idx]   = addr;
        req_wdata[idx]  = wdata;
        req_valid[idx]  = 1'b1;
        resp_ready[idx] = (hold == 0);
        waited = 0;
        while (!req_ready[idx] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready[idx]) begin
            checkOutput("accept_timeout", 32'(req_ready[idx]), 32'd1);
            req_valid[idx]  = 1'b0;
            resp_ready[idx] = 1'b1;
            return;
        end
        acceptCycle[idx] = cycle;
        @(negedge clk);
        req_valid[idx] = 1'b0;
        edges = 0;
        while (!resp_valid[idx] && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        checkOutput("latency", 32'(edges), 32'(waitModel[idx] + 1));
        if (!resp_valid[idx]) begin
            resp_ready[idx] = 1'b1;
            return;
        end
        checkOutput("req_ready_busy", 32'(req_ready[idx]), 32'd0);
        checkOutput("rdata", 32'(resp_rdata[idx]), 32'(expData));
        checkOutput("err", 32'(resp_err[idx]), 32'(expErr));
        for (int h = 0; h < hold; h++) begin
            req_valid[idx] = 1'b1;
            req_we[idx]    = 1'b0;
            req_addr[idx]  = 8'($urandom_range(0, 255));
            @(negedge clk);
            checkOutput("hold_valid", 32'(resp_valid[idx]), 32'd1);
            checkOutput("hold_rdata", 32'(resp_rdata[idx]), 32'(expData));
            checkOutput("hold_err", 32'(resp_err[idx]), 32'(expErr));
            checkOutput("hold_req_ready", 32'(req_ready[idx]), 32'd0);
        end
        req_valid[idx]  = 1'b0;
        resp_ready[idx] = 1'b1;
        if (we && !expErr) memModel[idx][addr] = wdata;
        @(negedge clk);
        checkOutput("post_valid", 32'(resp_valid[idx]), 32'd0);
        checkOutput("post_ready", 32'(req_ready[idx]), 32'd1);
    endtask

    task automatic pulseReset(input int idx, input string tag);
        rst[idx] = 1'b1;
        #1;
        checkOutput({tag, "_ready"}, 32'(req_ready[idx]), 32'd1);
        checkOutput({tag, "_valid"}, 32'(resp_valid[idx]), 32'd0);
        #1;
        rst[idx] = 1'b0;
        @(negedge clk);
    endtask

    // Resets while the access is still pending, so the store must be lost.
    task automatic resetInBusy(input int idx, input logic [7:0] addr, input logic [7:0] wdata);
        int waited;
        req_we[idx] = 1'b1;
        req_addr[idx] = addr;
        req_wdata[idx] = wdata;
        req_valid[idx] = 1'b1;
        resp_ready[idx] = 1'b1;
        waited = 0;
        while (!req_ready[idx] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("busy_accept", 32'(req_ready[idx]), 32'd1);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        pulseReset(idx, "rst_busy");
    endtask

    task automatic resetInResp(input int idx, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        int waited;
        req_we[idx] = we;
        req_addr[idx] = addr;
        req_wdata[idx] = wdata;
        req_valid[idx] = 1'b1;
        resp_ready[idx] = 1'b0;
        waited = 0;
        while (!resp_valid[idx] && waited < 40) begin
            @(negedge clk);
            if (req_ready[idx] == 1'b0) req_valid[idx] = 1'b0;
            waited++;
        end
        req_valid[idx] = 1'b0;
        checkOutput("resp_reach", 32'(resp_valid[idx]), 32'd1);
        if (we && int'(addr) < depthModel[idx]) memModel[idx][addr] = wdata;
        pulseReset(idx, "rst_resp");
        resp_ready[idx] = 1'b1;
    endtask

    initial begin
        int prevAccept;
        int r;
        logic [7:0] a;
        rst        = 2'b11;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 2'b11;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 256; j++)
                memModel[i][j] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_req_ready", 32'(req_ready[i]), 32'd1);
            checkOutput("reset_resp_valid", 32'(resp_valid[i]), 32'd0);
            checkOutput("reset_rdata", 32'(resp_rdata[i]), 32'd0);
            checkOutput("reset_err", 32'(resp_err[i]), 32'd0);
        end
        rst = 2'b00;
        @(negedge clk);

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < depthModel[i]; j++)
                applyStimulus(i, 1'b1, 8'(j), 8'h00, 0);

        applyStimulus(0, 1'b1, 8'h10, 8'h5A, 0);
        applyStimulus(0, 1'b0, 8'h10, 8'h00, 0);
        applyStimulus(0, 1'b0, 8'h10, 8'h00, 5);
        applyStimulus(0, 1'b1, 8'hC8, 8'hFF, 0);
        applyStimulus(0, 1'b0, 8'hC7, 8'h00, 0);
        applyStimulus(0, 1'b0, 8'hC8, 8'h00, 0);
        applyStimulus(1, 1'b1, 8'h00, 8'h11, 0);
        applyStimulus(1, 1'b1, 8'hFF, 8'h22, 0);
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 0);
        applyStimulus(1, 1'b0, 8'hFF, 8'h00, 0);
        resetInBusy(0, 8'h20, 8'h33);
        applyStimulus(0, 1'b0, 8'h20, 8'h00, 0);
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 0);
        prevAccept = acceptCycle[1];
        applyStimulus(1, 1'b0, 8'hFF, 8'h00, 0);
        checkOutput("accept_spacing", 32'(acceptCycle[1] - prevAccept), 32'd3);

        // Random traffic biased toward the DEPTH boundary and address extremes.
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 150; n++) begin
                r = int'($urandom_range(0, 19));
                case ($urandom_range(0, 3))
                    0:       a = 8'(depthModel[i] - 2 + int'($urandom_range(0, 3)));
                    1:       a = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                    default: a = 8'($urandom_range(0, 255));
                endcase
                if (r == 0)
                    resetInBusy(i, a, 8'($urandom));
                else if (r == 1)
                    resetInResp(i, 1'($urandom), a, 8'($urandom));
                else
                    applyStimulus(i, 1'($urandom), a, 8'($urandom), (r < 4) ? int'($urandom_range(1, 3)) : 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
